// File: rtl/issue_sequencer_if.sv
// issue_sequencer_if: fetch-pair input and dual-pipe issue output bundle.
// Rev 1.0
`default_nettype none

interface issue_sequencer_if #(
  parameter int INST_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INST_WIDTH-1:0] in_inst0;
  logic [INST_WIDTH-1:0] in_inst1;
  logic                  out_valid;
  logic                  out_ready;
  logic [INST_WIDTH-1:0] out_inst_a;
  logic [INST_WIDTH-1:0] out_inst_b;
  logic                  out_first;

  modport master (
    output in_valid, in_inst0, in_inst1, out_ready,
    input  in_ready, out_valid, out_inst_a, out_inst_b, out_first
  );

  modport slave (
    input  in_valid, in_inst0, in_inst1, out_ready,
    output in_ready, out_valid, out_inst_a, out_inst_b, out_first
  );
endinterface

`default_nettype wire

// File: rtl/issue_sequencer.sv
// issue_sequencer: steers an in-order instruction pair onto pipe A (branch/ALU)
// and pipe B (memory/ALU), splitting same-resource pairs over two cycles. Rev 1.0
`default_nettype none

module issue_sequencer #(
  parameter int          INST_WIDTH = 32,
  parameter int          OPCODE_LSB = 26,
  parameter logic [5:0]  OP_CMP     = 6'b001010,
  parameter logic [5:0]  OP_TEST    = 6'b001011,
  parameter logic [5:0]  OP_CMPI    = 6'b011010,
  parameter logic [5:0]  OP_TESTI   = 6'b011011
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  input  wire logic         flush,
  issue_sequencer_if.slave  bus,
  output logic [15:0]       split_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SPLIT} state_t;
  typedef enum logic [1:0] {CLS_X, CLS_MEM, CLS_BR} cls_t;

  localparam logic [INST_WIDTH-1:0] NOP = '0;

  state_t                  r_state;
  logic [INST_WIDTH-1:0]   r_inst0_q;
  logic [INST_WIDTH-1:0]   r_inst1_q;
  logic [15:0]             r_split_count;

  cls_t                    w_cls0;
  cls_t                    w_cls1;
  logic                    w_conflict;
  logic                    w_in_ready;
  logic                    w_xfer_in;
  logic [2*INST_WIDTH:0]   w_view;

  function automatic cls_t classify(input logic [5:0] op);
    cls_t c;
    case (op[5:4])
      2'b11:   c = CLS_BR;
      2'b10:   c = CLS_MEM;
      2'b01:   c = (op == OP_CMPI || op == OP_TESTI) ? CLS_BR : CLS_X;
      default: c = (op == OP_CMP  || op == OP_TEST)  ? CLS_BR : CLS_X;
    endcase
    return c;
  endfunction

  assign w_cls0     = classify(r_inst0_q[OPCODE_LSB+5:OPCODE_LSB]);
  assign w_cls1     = classify(r_inst1_q[OPCODE_LSB+5:OPCODE_LSB]);
  assign w_conflict = (w_cls0 == CLS_BR  && w_cls1 == CLS_BR) ||
                      (w_cls0 == CLS_MEM && w_cls1 == CLS_MEM);

  // A slot frees up only when the current one drains this cycle, except that a
  // conflicting pair still owes its younger half.
  assign w_in_ready = !flush &&
                      ((r_state == ST_EMPTY) ||
                       (bus.out_ready && (r_state == ST_SPLIT ||
                                          (r_state == ST_FULL && !w_conflict))));
  assign w_xfer_in  = bus.in_valid && w_in_ready;

  // Output view packed as {first, inst_a, inst_b}; a pure decode of held state.
  always_comb begin
    w_view = {1'b0, NOP, NOP};
    case (r_state)
      ST_FULL: begin
        if (w_cls0 == CLS_BR && w_cls1 == CLS_BR)
          w_view = {1'b0, r_inst0_q, NOP};
        else if (w_cls0 == CLS_MEM && w_cls1 == CLS_MEM)
          w_view = {1'b1, NOP, r_inst0_q};
        else if ((w_cls0 == CLS_MEM) || (w_cls0 == CLS_X && w_cls1 == CLS_BR))
          w_view = {1'b1, r_inst1_q, r_inst0_q};
        else
          w_view = {1'b0, r_inst0_q, r_inst1_q};
      end
      ST_SPLIT: begin
        if (w_cls1 == CLS_MEM)
          w_view = {1'b1, NOP, r_inst1_q};
        else
          w_view = {1'b0, r_inst1_q, NOP};
      end
      default: w_view = {1'b0, NOP, NOP};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_EMPTY;
      r_inst0_q     <= '0;
      r_inst1_q     <= '0;
      r_split_count <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer_in) begin
            r_inst0_q <= bus.in_inst0;
            r_inst1_q <= bus.in_inst1;
            r_state   <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            if (w_conflict) begin
              r_state <= ST_SPLIT;
              if (r_split_count != 16'hFFFF)
                r_split_count <= r_split_count + 16'd1;
            end else if (w_xfer_in) begin
              r_inst0_q <= bus.in_inst0;
              r_inst1_q <= bus.in_inst1;
              r_state   <= ST_FULL;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        ST_SPLIT: begin
          if (bus.out_ready) begin
            if (w_xfer_in) begin
              r_inst0_q <= bus.in_inst0;
              r_inst1_q <= bus.in_inst1;
              r_state   <= ST_FULL;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == ST_FULL) || (r_state == ST_SPLIT);
  assign bus.out_first  = w_view[2*INST_WIDTH];
  assign bus.out_inst_a = w_view[2*INST_WIDTH-1:INST_WIDTH];
  assign bus.out_inst_b = w_view[INST_WIDTH-1:0];
  assign split_count    = r_split_count;

endmodule

`default_nettype wire
